// File: rtl/pcie_sw_pwr_seq_multi_if.sv
// Per-channel control/status bundle of the PCIe switch power sequencer.
// slave = sequencer side, master = board/CPLD side.
interface pcie_sw_pwr_seq_multi_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] rail_pg;
  logic [NUM_CH-1:0] rail_en;
  logic [NUM_CH-1:0] sys_rst;
  logic [NUM_CH-1:0] prst;
  logic [NUM_CH-1:0] fault;
  logic              all_ready;

  modport master (
    output ch_en,
    output rail_pg,
    input  rail_en,
    input  sys_rst,
    input  prst,
    input  fault,
    input  all_ready
  );

  modport slave (
    input  ch_en,
    input  rail_pg,
    output rail_en,
    output sys_rst,
    output prst,
    output fault,
    output all_ready
  );
endinterface

// File: rtl/pcie_sw_pwr_seq_multi.sv
// N-channel PCIe switch rail/reset sequencer timed by the board 1 ms tick.
// Define PG_DEBOUNCE_EN to filter PG inputs over 3 agreeing tick samples.
module pcie_sw_pwr_seq_multi #(
  parameter int NUM_CH      = 2,
  parameter int RAIL_DLY_MS = 100,
  parameter int PG_TMO_MS   = 50,
  parameter int RST_LOW_MS  = 120,
  parameter int PRST_DLY_MS = 400,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_1ms,
  input  logic pg_1v8,
  pcie_sw_pwr_seq_multi_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_1V8,
    S_RAIL_ON,
    S_RST_LOW,
    S_RST_HIGH,
    S_RUN,
    S_FAULT
  } state_t;

  logic [NUM_CH:0]   pg_raw;
  logic [NUM_CH:0]   pg_s1;
  logic [NUM_CH:0]   pg_s2;
  logic [NUM_CH:0]   pg_f;
  logic              pg_ok;
  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] rs_v;
  logic [NUM_CH-1:0] pr_v;
  logic [NUM_CH-1:0] ft_v;
  logic [NUM_CH-1:0] run_n;
  logic              all_rdy;

  assign pg_raw = {pg_1v8, bus.rail_pg};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pg_s1 <= '0;
      pg_s2 <= '0;
    end else begin
      pg_s1 <= pg_raw;
      pg_s2 <= pg_s1;
    end
  end

`ifdef PG_DEBOUNCE_EN
  logic [NUM_CH:0][1:0] db_cnt;
  logic [NUM_CH:0]      db_q;

  // Flip only on the third consecutive disagreeing tick sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      db_q   <= '0;
    end else if (tick_1ms) begin
      for (int j = 0; j <= NUM_CH; j++) begin
        if (pg_s2[j] == db_q[j]) begin
          db_cnt[j] <= 2'd0;
        end else if (db_cnt[j] == 2'd2) begin
          db_q[j]   <= pg_s2[j];
          db_cnt[j] <= 2'd0;
        end else begin
          db_cnt[j] <= db_cnt[j] + 2'd1;
        end
      end
    end
  end

  assign pg_f = db_q;
`else
  assign pg_f = pg_s2;
`endif

  assign pg_ok = pg_f[NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           st;
    state_t           st_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] lim;
    logic [3:0]       rty;
    logic [3:0]       rty_n;
    logic             timed;
    logic             expired;
    logic             tear;
    logic             rpg;
    logic             en_q;
    logic             rs_q;
    logic             pr_q;
    logic             ft_q;

    assign rpg  = pg_f[i];
    assign tear = !bus.ch_en[i] || !pg_ok;

    always_comb begin
      lim   = '0;
      timed = 1'b1;
      unique case (st)
        S_WAIT_1V8: lim = CNT_W'(RAIL_DLY_MS);
        S_RAIL_ON:  lim = CNT_W'(PG_TMO_MS);
        S_RST_LOW:  lim = CNT_W'(RST_LOW_MS);
        S_RST_HIGH: lim = CNT_W'(PRST_DLY_MS);
        default:    timed = 1'b0;
      endcase
      expired = timed && (cnt >= lim);
    end

    // Tear-down is tested before timer expiry in every active state.
    always_comb begin
      st_n  = st;
      rty_n = rty;
      unique case (st)
        S_IDLE: begin
          if (bus.ch_en[i] && pg_ok) st_n = S_WAIT_1V8;
        end
        S_WAIT_1V8: begin
          if (tear)         st_n = S_IDLE;
          else if (expired) st_n = S_RAIL_ON;
        end
        S_RAIL_ON: begin
          if (tear) begin
            st_n = S_IDLE;
          end else if (rpg) begin
            st_n  = S_RST_LOW;
            rty_n = 4'd0;
          end else if (expired) begin
            if (rty < 4'(MAX_RETRY)) begin
              st_n  = S_IDLE;
              rty_n = rty + 4'd1;
            end else begin
              st_n = S_FAULT;
            end
          end
        end
        S_RST_LOW: begin
          if (tear || !rpg) st_n = S_IDLE;
          else if (expired) st_n = S_RST_HIGH;
        end
        S_RST_HIGH: begin
          if (tear || !rpg) st_n = S_IDLE;
          else if (expired) st_n = S_RUN;
        end
        S_RUN: begin
          if (tear || !rpg) st_n = S_IDLE;
        end
        S_FAULT: begin
          if (!bus.ch_en[i]) begin
            st_n  = S_IDLE;
            rty_n = 4'd0;
          end
        end
        default: st_n = S_IDLE;
      endcase

      cnt_n = cnt;
      if (st_n != st)                    cnt_n = '0;
      else if (tick_1ms && timed && !expired) cnt_n = cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st   <= S_IDLE;
        cnt  <= '0;
        rty  <= 4'd0;
        en_q <= 1'b0;
        rs_q <= 1'b0;
        pr_q <= 1'b0;
        ft_q <= 1'b0;
      end else begin
        st   <= st_n;
        cnt  <= cnt_n;
        rty  <= rty_n;
        en_q <= st_n inside {S_RAIL_ON, S_RST_LOW, S_RST_HIGH, S_RUN};
        rs_q <= st_n inside {S_RST_HIGH, S_RUN};
        pr_q <= (st_n == S_RUN);
        ft_q <= (st_n == S_FAULT);
      end
    end

    assign en_v[i]  = en_q;
    assign rs_v[i]  = rs_q;
    assign pr_v[i]  = pr_q;
    assign ft_v[i]  = ft_q;
    assign run_n[i] = (st_n == S_RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) all_rdy <= 1'b0;
    else        all_rdy <= (|bus.ch_en) & (&(run_n | ~bus.ch_en));
  end

  assign bus.rail_en   = en_v;
  assign bus.sys_rst   = rs_v;
  assign bus.prst      = pr_v;
  assign bus.fault     = ft_v;
  assign bus.all_ready = all_rdy;

endmodule
